password_lock_controller: RTL and testbench

// Sequencer for the password lock: collects keypad digits, compares the code

---
 rtl/password_lock_controller_if.sv | 25 ++
 rtl/password_lock_controller.sv | 139 +++++++++++++
 tb/tb_password_lock_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/password_lock_controller_if.sv
// Keypad/status bundle between the keypad front end and the password lock sequencer.
// master drives the keypad strobes and the time base; slave is the lock controller.
interface password_lock_controller_if #(
   parameter int DIGIT_W = 4
);
   logic               clk_div;
   logic               key_valid;
   logic [DIGIT_W-1:0] key_digit;
   logic               key_clear;
   logic               unlocked;
   logic               alarm;
   logic               fail_pulse;
   logic [2:0]         digit_count;
   logic [3:0]         attempts_left;

   modport master (
      output clk_div, key_valid, key_digit, key_clear,
      input  unlocked, alarm, fail_pulse, digit_count, attempts_left
   );

   modport slave (
      input  clk_div, key_valid, key_digit, key_clear,
      output unlocked, alarm, fail_pulse, digit_count, attempts_left
   );
endinterface

// File: rtl/password_lock_controller.sv
// Password lock sequencer: digit collection, code check, timed unlock window and
// wrong-code lockout, timed by ticks recovered from the divided clock.
module password_lock_controller #(
   parameter int                           DIGITS        = 4,
   parameter int                           DIGIT_W       = 4,
   parameter logic [DIGITS*DIGIT_W-1:0]    PASSWORD      = 16'h1234,
   parameter int                           MAX_ATTEMPTS  = 3,
   parameter int                           UNLOCK_TICKS  = 5,
   parameter int                           LOCKOUT_TICKS = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   password_lock_controller_if.slave  bus
);

   localparam int          CODE_W     = DIGITS * DIGIT_W;
   localparam logic [2:0]  LAST_COUNT = 3'(DIGITS - 1);
   localparam logic [3:0]  FULL_TRIES = 4'(MAX_ATTEMPTS);
   localparam logic [15:0] OPEN_LOAD  = 16'(UNLOCK_TICKS);
   localparam logic [15:0] LOCK_LOAD  = 16'(LOCKOUT_TICKS);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_CHECK   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   state_t              state_r;
   logic [CODE_W-1:0]   entry_r;
   logic [2:0]          count_r;
   logic [3:0]          attempts_r;
   logic [15:0]         timer_r;
   logic                fail_r;
   logic                div_meta_r;
   logic                div_sync_r;
   logic                div_prev_r;
   logic                tick_s;

   // Two-flop synchronizer plus edge history for the divided-clock time base.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_meta_r <= 1'b0;
         div_sync_r <= 1'b0;
         div_prev_r <= 1'b0;
      end else begin
         div_meta_r <= bus.clk_div;
         div_sync_r <= div_meta_r;
         div_prev_r <= div_sync_r;
      end
   end

   assign tick_s = div_sync_r & ~div_prev_r;

   // Lock sequencer: state, entry shift register, attempt counter, window timer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_ENTRY;
         entry_r    <= '0;
         count_r    <= 3'd0;
         attempts_r <= FULL_TRIES;
         timer_r    <= 16'd0;
         fail_r     <= 1'b0;
      end else begin
         fail_r <= 1'b0;
         case (state_r)
            ST_ENTRY: begin
               if (bus.key_clear) begin
                  entry_r <= '0;
                  count_r <= 3'd0;
               end else if (bus.key_valid) begin
                  entry_r <= (entry_r << DIGIT_W) | CODE_W'(bus.key_digit);
                  count_r <= count_r + 3'd1;
                  if (count_r == LAST_COUNT) begin
                     state_r <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               entry_r <= '0;
               count_r <= 3'd0;
               if (entry_r == PASSWORD) begin
                  state_r    <= ST_OPEN;
                  timer_r    <= OPEN_LOAD;
                  attempts_r <= FULL_TRIES;
               end else begin
                  fail_r <= 1'b1;
                  // Treat an already-empty counter as the last attempt so it cannot wrap.
                  if (attempts_r <= 4'd1) begin
                     attempts_r <= 4'd0;
                     state_r    <= ST_LOCKOUT;
                     timer_r    <= LOCK_LOAD;
                  end else begin
                     attempts_r <= attempts_r - 4'd1;
                     state_r    <= ST_ENTRY;
                  end
               end
            end
            ST_OPEN: begin
               if (bus.key_clear) begin
                  state_r <= ST_ENTRY;
                  timer_r <= 16'd0;
               end else if (tick_s) begin
                  if (timer_r == 16'd1) begin
                     state_r <= ST_ENTRY;
                  end
                  if (timer_r != 16'd0) begin
                     timer_r <= timer_r - 16'd1;
                  end
               end
            end
            ST_LOCKOUT: begin
               if (tick_s) begin
                  if (timer_r == 16'd1) begin
                     state_r    <= ST_ENTRY;
                     attempts_r <= FULL_TRIES;
                  end
                  if (timer_r != 16'd0) begin
                     timer_r <= timer_r - 16'd1;
                  end
               end
            end
            default: begin
               state_r <= ST_ENTRY;
               entry_r <= '0;
               count_r <= 3'd0;
               timer_r <= 16'd0;
            end
         endcase
      end
   end

   assign bus.unlocked      = (state_r == ST_OPEN);
   assign bus.alarm         = (state_r == ST_LOCKOUT);
   assign bus.fail_pulse    = fail_r;
   assign bus.digit_count   = count_r;
   assign bus.attempts_left = attempts_r;

endmodule

// File: tb/tb_password_lock_controller.sv
// Directed bench for the password lock: a per-cycle vector table for keypad
// behaviour, then hand-written sequences for the timed windows and reset.
module tb_password_lock_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #10 clk = ~clk;

   password_lock_controller_if #(.DIGIT_W(4)) bus ();

   password_lock_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       kv;
      logic [3:0] kd;
      logic       kc;
      logic [2:0] cnt;
      logic       unl;
      logic       alm;
      logic       fp;
      logic [3:0] att;
   } vec_t;

   vec_t vecs [22];

   function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic kc,
                               input logic [2:0] cnt, input logic unl, input logic alm,
                               input logic fp, input logic [3:0] att);
      vec_t v;
      v.kv = kv; v.kd = kd; v.kc = kc;
      v.cnt = cnt; v.unl = unl; v.alm = alm; v.fp = fp; v.att = att;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] cnt, input logic unl,
                             input logic alm, input logic fp, input logic [3:0] att);
      chk({tag, " digit_count"},   16'(bus.digit_count),   16'(cnt));
      chk({tag, " unlocked"},      16'(bus.unlocked),      16'(unl));
      chk({tag, " alarm"},         16'(bus.alarm),         16'(alm));
      chk({tag, " fail_pulse"},    16'(bus.fail_pulse),    16'(fp));
      chk({tag, " attempts_left"}, 16'(bus.attempts_left), 16'(att));
   endtask

   // One clock with the given strobes; outputs are then read 1 ns after the edge.
   task automatic step(input logic kv, input logic [3:0] kd, input logic kc);
      bus.key_valid = kv;
      bus.key_digit = kd;
      bus.key_clear = kc;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
      bus.key_clear = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] code);
      logic [15:0] c;
      c = code;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, c[15:12], 1'b0);
         c = c << 4;
      end
   endtask

   task automatic div_rise();
      bus.clk_div = 1'b1;
      repeat (4) step(1'b0, 4'd0, 1'b0);
      bus.clk_div = 1'b0;
      repeat (4) step(1'b0, 4'd0, 1'b0);
   endtask

   // Three wrong codes from a full attempt count, ending in lockout.
   task automatic drive_to_lockout(input string tag);
      for (int n = 0; n < 3; n++) begin
         enter_code(16'h1235);
         step(1'b0, 4'd0, 1'b0);
         chk({tag, " fail_pulse"}, 16'(bus.fail_pulse), 16'd1);
         chk({tag, " attempts"}, 16'(bus.attempts_left), 16'(2 - n));
         step(1'b0, 4'd0, 1'b0);
      end
      chk({tag, " alarm"}, 16'(bus.alarm), 16'd1);
   endtask

   initial begin
      bus.clk_div   = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
      bus.key_clear = 1'b0;

      vecs[0]  = mk(1'b1, 4'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[1]  = mk(1'b1, 4'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[2]  = mk(1'b1, 4'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[3]  = mk(1'b1, 4'd4, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[4]  = mk(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3);
      vecs[5]  = mk(1'b1, 4'd7, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3);
      vecs[6]  = mk(1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[7]  = mk(1'b1, 4'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[8]  = mk(1'b1, 4'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[9]  = mk(1'b1, 4'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[10] = mk(1'b1, 4'd5, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 4'd3);
      vecs[11] = mk(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd2);
      vecs[12] = mk(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[13] = mk(1'b1, 4'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[14] = mk(1'b1, 4'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[15] = mk(1'b1, 4'd9, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[16] = mk(1'b1, 4'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[17] = mk(1'b1, 4'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[18] = mk(1'b1, 4'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[19] = mk(1'b1, 4'd4, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 4'd2);
      vecs[20] = mk(1'b1, 4'd8, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd3);
      vecs[21] = mk(1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd3);

      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd3);
      rst = 1'b1;
      step(1'b0, 4'd0, 1'b0);

      for (int i = 0; i < 22; i++) begin
         step(vecs[i].kv, vecs[i].kd, vecs[i].kc);
         check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].unl,
                    vecs[i].alm, vecs[i].fp, vecs[i].att);
      end

      // Unlock window closes 3 clk after the 5th clk_div rise.
      enter_code(16'h1234);
      step(1'b0, 4'd0, 1'b0);
      chk("win open", 16'(bus.unlocked), 16'd1);
      repeat (4) div_rise();
      chk("win after 4 ticks", 16'(bus.unlocked), 16'd1);
      bus.clk_div = 1'b1;
      repeat (2) step(1'b0, 4'd0, 1'b0);
      chk("win 2clk after 5th rise", 16'(bus.unlocked), 16'd1);
      step(1'b0, 4'd0, 1'b0);
      chk("win 3clk after 5th rise", 16'(bus.unlocked), 16'd0);
      bus.clk_div = 1'b0;
      repeat (4) step(1'b0, 4'd0, 1'b0);

      // Lockout: keys ignored, alarm lasts 10 ticks, attempts restored.
      drive_to_lockout("lock");
      check_outs("lock state", 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      step(1'b1, 4'd1, 1'b0);
      chk("lock key ignored", 16'(bus.digit_count), 16'd0);
      step(1'b0, 4'd0, 1'b1);
      chk("lock clear ignored", 16'(bus.alarm), 16'd1);
      repeat (9) div_rise();
      check_outs("lock after 9 ticks", 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
      bus.clk_div = 1'b1;
      repeat (2) step(1'b0, 4'd0, 1'b0);
      chk("lock 2clk after 10th", 16'(bus.alarm), 16'd1);
      step(1'b0, 4'd0, 1'b0);
      check_outs("lock released", 3'd0, 1'b0, 1'b0, 1'b0, 4'd3);
      bus.clk_div = 1'b0;
      repeat (4) step(1'b0, 4'd0, 1'b0);

      // Asynchronous reset in the middle of a lockout (timer at 6).
      drive_to_lockout("rlock");
      repeat (4) div_rise();
      chk("rlock timer6 alarm", 16'(bus.alarm), 16'd1);
      rst = 1'b0;
      #5;
      check_outs("mid reset", 3'd0, 1'b0, 1'b0, 1'b0, 4'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      enter_code(16'h1234);
      step(1'b0, 4'd0, 1'b0);
      check_outs("post reset unlock", 3'd0, 1'b1, 1'b0, 1'b0, 4'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
